// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared vector load/store types and default sizes
package vec_pkg;

    localparam int ELEMS_DEF = 16;
    localparam int DW_DEF    = 16;
    localparam int AW_DEF    = 16;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_RUN,
        S_LD_DRAIN,
        S_ST_RUN,
        S_ST_DRAIN,
        S_DONE
    } vec_state_e;

endpackage

// File: rtl/vec_addr_gen.sv
// rtl/vec_addr_gen.sv - base/stride address accumulator with load and step enables
module vec_addr_gen
    import vec_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          Clk1,
    input  logic          Rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] stride,
    output logic [AW-1:0] addr
);

    logic [AW-1:0] stride_q;

    // Modulo-2^AW accumulation: wrapping past the top of memory is intended.
    always_ff @(posedge Clk1 or negedge Rst_n) begin
        if (!Rst_n) begin
            addr     <= '0;
            stride_q <= '0;
        end else if (load) begin
            addr     <= base;
            stride_q <= stride;
        end else if (step) begin
            addr     <= addr + stride_q;
        end
    end

endmodule

// File: rtl/vec_ldst_seq.sv
// rtl/vec_ldst_seq.sv - serial vector load/store sequencer between data memory and vector file
module vec_ldst_seq
    import vec_pkg::*;
#(
    parameter int ELEMS = ELEMS_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          Clk1,
    input  logic          Rst_n,
    input  logic          Start,
    input  logic          Op,
    input  logic [2:0]    VReg,
    input  logic [AW-1:0] Base,
    input  logic [AW-1:0] Stride,
    output logic          Busy,
    output logic          Done,
    output logic [2:0]    VR_Addr,
    output logic          VR_WR_s,
    output logic          VR_RD_s,
    output logic [DW-1:0] VR_DataOut,
    input  logic [DW-1:0] VR_DataIn,
    output logic [AW-1:0] Mem_Addr,
    output logic          Mem_RD,
    output logic          Mem_WR,
    output logic [DW-1:0] Mem_DataOut,
    input  logic [DW-1:0] Mem_DataIn
);

    localparam int            CW   = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ELEMS - 1);

    vec_state_e    state;
    logic [CW-1:0] cnt;
    logic          ag_load;
    logic          ag_step;

    // Load steps ahead of the read strobe; store steps one beat behind, trailing the file's read latency.
    assign ag_load = (state == S_IDLE) && Start;
    assign ag_step = ((state == S_LD_RUN) && (cnt != LAST)) ||
                     ((state == S_ST_RUN) && (cnt != '0));

    vec_addr_gen #(.AW(AW)) u_addr_gen (
        .Clk1   (Clk1),
        .Rst_n  (Rst_n),
        .load   (ag_load),
        .step   (ag_step),
        .base   (Base),
        .stride (Stride),
        .addr   (Mem_Addr)
    );

    // Memory read data and file read data are already register outputs; gating keeps idle buses at zero.
    assign VR_DataOut  = VR_WR_s ? Mem_DataIn : '0;
    assign Mem_DataOut = Mem_WR  ? VR_DataIn  : '0;

    always_ff @(posedge Clk1 or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            VR_Addr <= '0;
            VR_WR_s <= 1'b0;
            VR_RD_s <= 1'b0;
            Mem_RD  <= 1'b0;
            Mem_WR  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        VR_Addr <= VReg;
                        cnt     <= '0;
                        Busy    <= 1'b1;
                        if (Op == OP_LOAD) begin
                            state  <= S_LD_RUN;
                            Mem_RD <= 1'b1;
                        end else begin
                            state   <= S_ST_RUN;
                            VR_RD_s <= 1'b1;
                        end
                    end
                end
                S_LD_RUN: begin
                    cnt     <= cnt + CW'(1);
                    VR_WR_s <= 1'b1;
                    if (cnt == LAST) begin
                        Mem_RD <= 1'b0;
                        state  <= S_LD_DRAIN;
                    end
                end
                S_LD_DRAIN: begin
                    VR_WR_s <= 1'b0;
                    Done    <= 1'b1;
                    state   <= S_DONE;
                end
                S_ST_RUN: begin
                    cnt    <= cnt + CW'(1);
                    Mem_WR <= 1'b1;
                    if (cnt == LAST) begin
                        VR_RD_s <= 1'b0;
                        state   <= S_ST_DRAIN;
                    end
                end
                S_ST_DRAIN: begin
                    Mem_WR <= 1'b0;
                    Done   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    // Strobes are already low here, so back-to-back commands see a restart edge.
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
